// File: rtl/dmem_bridge.sv
// MEM-stage data-bus bridge: turns one pipeline memory access into exactly one
// SRAM-like split address/data transaction and stalls the pipeline until it completes.
module dmem_bridge #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [3:0]  wea,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedata,
    input  logic        flushM,
    input  logic        advanceM,
    output logic [31:0] readdata,
    output logic        d_stall,
    output logic        bus_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);
    localparam bit               WD_EN    = (TIMEOUT != 0);

    state_t            state_q, state_d;
    logic              cancel_q, cancel_d;
    logic              data_req_q, data_req_d;
    logic              data_wr_q, data_wr_d;
    logic [3:0]        data_wstrb_q, data_wstrb_d;
    logic [31:0]       data_addr_q, data_addr_d;
    logic [31:0]       data_wdata_q, data_wdata_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic              bus_err_q, bus_err_d;

    logic issue;
    logic waiting;
    logic resp;
    logic cancel_eff;
    logic keep_result;
    logic stall_c;
    logic unused_addr_lsb;

    // Byte offset is irrelevant on a word-addressed bus; the strobes carry it.
    assign unused_addr_lsb = ^aluoutM[1:0];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (memenM && !flushM) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        state_d = cancel_eff ? IDLE : DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (data_data_ok) begin
                    state_d = cancel_eff ? IDLE : DONE;
                end
            end
            DONE: begin
                if (advanceM || flushM) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        issue       = (state_q == IDLE) && memenM && !flushM;
        waiting     = (state_q == ADDR) || (state_q == DATA);
        resp        = ((state_q == ADDR) && data_addr_ok && data_data_ok) ||
                      ((state_q == DATA) && data_data_ok);
        // A flush arriving in the completion cycle still discards the data.
        cancel_eff  = cancel_q || flushM;
        keep_result = resp && !cancel_eff;
        stall_c     = issue || waiting;
    end

    // ------------------------------------------------------------------
    // Request capture: fields frozen from issue until the next issue
    // ------------------------------------------------------------------
    always_comb begin
        data_req_d  = (state_d == ADDR);
        data_wr_d   = issue ? memwriteM : data_wr_q;
        data_addr_d = issue ? {aluoutM[31:2], 2'b00} : data_addr_q;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign data_wstrb_d[gi]        = issue ? wea[gi] : data_wstrb_q[gi];
            assign data_wdata_d[8*gi +: 8] = issue ? writedata[8*gi +: 8]
                                                   : data_wdata_q[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Result, cancel tracking and watchdog
    // ------------------------------------------------------------------
    always_comb begin
        readdata_d = keep_result ? data_rdata : readdata_q;

        cancel_d = cancel_q;
        if (resp) begin
            cancel_d = 1'b0;
        end else if (waiting && flushM) begin
            cancel_d = 1'b1;
        end

        // Saturates at the limit so a long hang cannot wrap and look healthy.
        wd_cnt_d = wd_cnt_q;
        if (issue) begin
            wd_cnt_d = '0;
        end else if (waiting && (wd_cnt_q != WD_LIMIT)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        bus_err_d = bus_err_q;
        if (WD_EN && waiting && (wd_cnt_q == WD_LIMIT)) begin
            bus_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cancel_q     <= 1'b0;
            data_req_q   <= 1'b0;
            data_wr_q    <= 1'b0;
            data_wstrb_q <= 4'b0000;
            data_addr_q  <= 32'd0;
            data_wdata_q <= 32'd0;
            readdata_q   <= 32'd0;
            wd_cnt_q     <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            cancel_q     <= cancel_d;
            data_req_q   <= data_req_d;
            data_wr_q    <= data_wr_d;
            data_wstrb_q <= data_wstrb_d;
            data_addr_q  <= data_addr_d;
            data_wdata_q <= data_wdata_d;
            readdata_q   <= readdata_d;
            wd_cnt_q     <= wd_cnt_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign d_stall    = stall_c;
    assign readdata   = readdata_q;
    assign bus_err    = bus_err_q;
    assign data_req   = data_req_q;
    assign data_wr    = data_wr_q;
    assign data_wstrb = data_wstrb_q;
    assign data_addr  = data_addr_q;
    assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: transaction-level model compared every cycle,
// plus literal expectations taken from hand-traced cycle timelines.
module tb_dmem_bridge;

    localparam int TMO = 8;

    logic        clk;
    logic        rst;
    logic        memenM;
    logic        memwriteM;
    logic [3:0]  wea;
    logic [31:0] aluoutM;
    logic [31:0] writedata;
    logic        flushM;
    logic        advanceM;
    logic [31:0] readdata;
    logic        d_stall;
    logic        bus_err;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    dmem_bridge #(.TIMEOUT(TMO), .CNT_W(9)) dut (
        .clk          (clk),
        .rst          (rst),
        .memenM       (memenM),
        .memwriteM    (memwriteM),
        .wea          (wea),
        .aluoutM      (aluoutM),
        .writedata    (writedata),
        .flushM       (flushM),
        .advanceM     (advanceM),
        .readdata     (readdata),
        .d_stall      (d_stall),
        .bus_err      (bus_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int hs_cnt = 0;

    // Transaction-level model: one access is "busy" from issue to response,
    // optionally still waiting for the address handshake, then "done" until advance.
    bit        m_busy, m_req, m_done, m_cancel, m_err;
    int        m_wait;
    bit        m_wr;
    bit [3:0]  m_strb;
    bit [31:0] m_addr, m_wdata, m_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit cx;
        bit finished;
        if (rst) begin
            m_busy = 0; m_req = 0; m_done = 0; m_cancel = 0; m_err = 0; m_wait = 0;
            m_wr = 0; m_strb = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
        end else begin
            if (data_req && data_addr_ok) hs_cnt++;
            if (m_done) begin
                if (advanceM || flushM) m_done = 0;
            end else if (m_busy) begin
                if (m_wait == TMO) m_err = 1;
                if (m_wait < TMO) m_wait++;
                cx = m_cancel || flushM;
                if (flushM) m_cancel = 1;
                finished = m_req ? (data_addr_ok && data_data_ok) : data_data_ok;
                if (finished) begin
                    m_busy = 0; m_req = 0; m_cancel = 0;
                    if (!cx) begin
                        m_done = 1;
                        m_rd = data_rdata;
                    end
                end else if (m_req && data_addr_ok) begin
                    m_req = 0;
                end
            end else if (memenM && !flushM) begin
                m_busy = 1; m_req = 1; m_wait = 0; m_cancel = 0;
                m_wr = memwriteM; m_strb = wea;
                m_addr = aluoutM & 32'hFFFF_FFFC; m_wdata = writedata;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_stall", {31'd0, d_stall}, {31'd0, m_busy | (!m_done & memenM & !flushM)});
            chk("m_req",   {31'd0, data_req}, {31'd0, m_req});
            chk("m_wr",    {31'd0, data_wr}, {31'd0, m_wr});
            chk("m_strb",  {28'd0, data_wstrb}, {28'd0, m_strb});
            chk("m_addr",  data_addr, m_addr);
            chk("m_wdata", data_wdata, m_wdata);
            chk("m_rdata", readdata, m_rd);
            chk("m_err",   {31'd0, bus_err}, {31'd0, m_err});
        end
    end

    task automatic drive(input logic men, input logic wr, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic fl, input logic adv, input logic aok,
                         input logic dok, input logic [31:0] rd);
        memenM = men; memwriteM = wr; wea = we; aluoutM = addr; writedata = wd;
        flushM = fl; advanceM = adv; data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic fin();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        mid();
        fin();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int hs0;
        rst = 1'b1;
        drive(0, 0, 4'b0, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        @(posedge clk); #1;
        repeat (3) fin();
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state
        mid();
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_stall", {31'd0, d_stall}, 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_err", {31'd0, bus_err}, 32'd0);
        chk("rst_addr", data_addr, 32'd0);
        fin();

        // Load, same-cycle addr_ok/data_ok
        drive(1, 0, 4'b0000, 32'h1004, 32'd0, 0, 0, 0, 0, 32'd0);
        mid(); chk("ld_c0_stall", {31'd0, d_stall}, 32'd1); fin();
        drive(1, 0, 4'b0000, 32'h1004, 32'd0, 0, 0, 1, 1, 32'hDEADBEEF);
        mid();
        chk("ld_c1_req", {31'd0, data_req}, 32'd1);
        chk("ld_c1_addr", data_addr, 32'h1004);
        chk("ld_c1_strb", {28'd0, data_wstrb}, 32'd0);
        fin();
        drive(1, 0, 4'b0000, 32'h1004, 32'd0, 0, 1, 0, 0, 32'd0);
        mid();
        chk("ld_c2_stall", {31'd0, d_stall}, 32'd0);
        chk("ld_c2_rdata", readdata, 32'hDEADBEEF);
        fin();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        tick();

        // Store byte, addr_ok cycle 3, data_ok cycle 6
        for (int c = 0; c <= 7; c++) begin
            drive(1, 1, 4'b1000, 32'h2003, 32'h5A00_0000, 0, 0,
                  (c == 3), (c == 6), (c == 6) ? 32'h1111_2222 : 32'd0);
            mid();
            chk("st_stall", {31'd0, d_stall}, (c <= 6) ? 32'd1 : 32'd0);
            if (c == 3) begin
                chk("st_addr", data_addr, 32'h2000);
                chk("st_strb", {28'd0, data_wstrb}, 32'h8);
                chk("st_wr", {31'd0, data_wr}, 32'd1);
                chk("st_wdata", data_wdata, 32'h5A00_0000);
            end
            fin();
        end
        // DONE held with advanceM low: no new request, result stable
        for (int c = 0; c < 4; c++) begin
            drive(1, 1, 4'b1000, 32'h2003, 32'h5A00_0000, 0, 0, 0, 0, 32'd0);
            mid();
            chk("hold_req", {31'd0, data_req}, 32'd0);
            chk("hold_rdata", readdata, 32'h1111_2222);
            fin();
        end
        drive(1, 1, 4'b1000, 32'h2003, 32'h5A00_0000, 0, 1, 0, 0, 32'd0);
        tick();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        tick();

        // Flush in IDLE: nothing issued
        drive(1, 0, 4'b0000, 32'h3000, 32'd0, 1, 0, 0, 0, 32'd0);
        mid(); chk("fli_stall", {31'd0, d_stall}, 32'd0); fin();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        mid(); chk("fli_req", {31'd0, data_req}, 32'd0); fin();

        // Flush while in DATA: response discarded, back to IDLE
        drive(1, 0, 4'b0000, 32'h3000, 32'd0, 0, 0, 0, 0, 32'd0); tick();
        drive(1, 0, 4'b0000, 32'h3000, 32'd0, 0, 0, 1, 0, 32'd0); tick();
        drive(1, 0, 4'b0000, 32'h3000, 32'd0, 1, 0, 0, 0, 32'd0);
        mid(); chk("fld_stall_fl", {31'd0, d_stall}, 32'd1); fin();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        mid(); chk("fld_stall_wait", {31'd0, d_stall}, 32'd1); fin();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 1, 32'h1234_5678); tick();
        drive(1, 0, 4'b0000, 32'h3008, 32'd0, 0, 0, 0, 0, 32'd0);
        mid();
        chk("fld_rdata_kept", readdata, 32'h1111_2222);
        chk("fld_idle_stall", {31'd0, d_stall}, 32'd1);
        fin();
        drive(1, 0, 4'b0000, 32'h3008, 32'd0, 0, 0, 1, 1, 32'hCAFE_0001); tick();
        drive(1, 0, 4'b0000, 32'h3008, 32'd0, 0, 1, 0, 0, 32'd0);
        mid(); chk("fld_next_rdata", readdata, 32'hCAFE_0001); fin();

        // Stray data_ok in IDLE is ignored
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 1, 32'hFFFF_FFFF); tick();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        mid(); chk("stray_rdata", readdata, 32'hCAFE_0001); fin();

        // Back-to-back load then store
        hs0 = hs_cnt;
        drive(1, 0, 4'b0000, 32'h5008, 32'd0, 0, 0, 0, 0, 32'd0); tick();
        drive(1, 0, 4'b0000, 32'h5008, 32'd0, 0, 0, 1, 1, 32'h55AA_55AA);
        mid(); chk("b2b_ld_addr", data_addr, 32'h5008); fin();
        drive(1, 0, 4'b0000, 32'h5008, 32'd0, 0, 1, 0, 0, 32'd0);
        mid(); chk("b2b_ld_rdata", readdata, 32'h55AA_55AA); fin();
        drive(1, 1, 4'b0011, 32'h600E, 32'h0000_ABCD, 0, 0, 0, 0, 32'd0); tick();
        drive(1, 1, 4'b0011, 32'h600E, 32'h0000_ABCD, 0, 0, 1, 0, 32'd0);
        mid();
        chk("b2b_st_addr", data_addr, 32'h600C);
        chk("b2b_st_strb", {28'd0, data_wstrb}, 32'h3);
        chk("b2b_st_wdata", data_wdata, 32'h0000_ABCD);
        fin();
        drive(1, 1, 4'b0011, 32'h600E, 32'h0000_ABCD, 0, 0, 0, 1, 32'h0); tick();
        drive(1, 1, 4'b0011, 32'h600E, 32'h0000_ABCD, 0, 1, 0, 0, 32'd0); tick();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0); tick();
        chk("b2b_handshakes", hs_cnt - hs0, 32'd2);

        // Watchdog: data_ok withheld
        for (int c = 0; c <= 10; c++) begin
            drive(1, 0, 4'b0000, 32'h4000, 32'd0, 0, 0, 0, 0, 32'd0);
            mid();
            if (c == 9)  chk("wd_c9_err", {31'd0, bus_err}, 32'd0);
            if (c == 10) chk("wd_c10_err", {31'd0, bus_err}, 32'd1);
            fin();
        end
        drive(1, 0, 4'b0000, 32'h4000, 32'd0, 0, 0, 1, 1, 32'h0BAD_F00D); tick();
        drive(1, 0, 4'b0000, 32'h4000, 32'd0, 0, 1, 0, 0, 32'd0);
        mid();
        chk("wd_sticky", {31'd0, bus_err}, 32'd1);
        chk("wd_late_rdata", readdata, 32'h0BAD_F00D);
        fin();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0); tick();

        // Reset mid-transaction clears the request and the error
        drive(1, 0, 4'b0000, 32'h7000, 32'd0, 0, 0, 0, 0, 32'd0); tick();
        drive(0, 0, 4'b0000, 32'd0, 32'd0, 0, 0, 0, 0, 32'd0);
        rst = 1'b1;
        mid(); chk("rstm_req_before", {31'd0, data_req}, 32'd1); fin();
        rst = 1'b0;
        mid();
        chk("rstm_req", {31'd0, data_req}, 32'd0);
        chk("rstm_stall", {31'd0, d_stall}, 32'd0);
        chk("rstm_err", {31'd0, bus_err}, 32'd0);
        fin();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
